// File: rtl/axis_i2c_cmd_seq_if.sv
// AXI-Stream command channel between the sequencer and the I2C master core.
interface axis_i2c_cmd_seq_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_i2c_cmd_seq.sv
// Command sequencer: plays a writable table of I2C commands over AXI-Stream,
// waits for the core's done/NACK status, retries NACKs, supports loop playback.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | table read of entry idx in flight
// SEND  | beat presented on the stream, held until tready
// WAIT  | beat accepted, waiting for the I2C core status
// DONE  | one-cycle success pulse
module axis_i2c_cmd_seq #(
    parameter int DATA_W      = 16,
    parameter int NUM_ENTRIES = 16,
    parameter int MAX_RETRY   = 3,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       cfg_we_i,
    input  logic [IDX_W-1:0]           cfg_addr_i,
    input  logic [DATA_W-1:0]          cfg_wdata_i,
    input  logic [IDX_W:0]             num_cmds_i,
    input  logic                       loop_en_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    axis_i2c_cmd_seq_if.master         m_axis,
    input  logic                       i2c_done_i,
    input  logic                       i2c_nack_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       error_o,
    output logic [IDX_W-1:0]           err_idx_o
);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [IDX_W:0] ONE = 1;

    typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RW-1:0]      retry_q, retry_d;
    logic [IDX_W:0]     num_q, num_d;
    logic               loop_q, loop_d;
    logic               stop_q, stop_d;
    logic               error_q, error_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;
    logic [DATA_W-1:0]  tdata_q;
    logic               tlast_q;
    logic               is_last;
    logic [DATA_W-1:0]  mem_q [NUM_ENTRIES];

    assign is_last = ({1'b0, idx_q} == (num_q - ONE));

    // Command table: write port is always open; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (cfg_we_i) begin
            mem_q[cfg_addr_i] <= cfg_wdata_i;
        end
    end

    // Beat register: loaded once per FETCH, held through SEND and any retries.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            tdata_q <= '0;
            tlast_q <= 1'b0;
        end else if (state_q == FETCH) begin
            tdata_q <= mem_q[idx_q];
            tlast_q <= is_last;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            retry_q   <= '0;
            num_q     <= '0;
            loop_q    <= 1'b0;
            stop_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            num_q     <= num_d;
            loop_q    <= loop_d;
            stop_q    <= stop_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
        end
    end

    // Next-state logic: sequencing, retry accounting and stop handling.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        num_d     = num_q;
        loop_d    = loop_q;
        stop_d    = stop_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;

        if (stop_i && (state_q != IDLE)) begin
            stop_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                stop_d = 1'b0;
                if (start_i) begin
                    num_d   = num_cmds_i;
                    loop_d  = loop_en_i;
                    idx_d   = '0;
                    retry_d = '0;
                    error_d = 1'b0;
                    state_d = (num_cmds_i == '0) ? DONE : FETCH;
                end
            end
            FETCH: state_d = SEND;
            SEND: begin
                if (m_axis.tready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (i2c_done_i) begin
                    stop_d = 1'b0;
                    if (!i2c_nack_i) begin
                        retry_d = '0;
                        if (stop_q || stop_i) begin
                            state_d = DONE;
                        end else if (is_last) begin
                            if (loop_q) begin
                                idx_d   = '0;
                                state_d = FETCH;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = FETCH;
                        end
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = SEND;
                    end else begin
                        error_d   = 1'b1;
                        err_idx_d = idx_q;
                        state_d   = IDLE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = (state_q == SEND);
    assign m_axis.tlast  = tlast_q && (state_q == SEND);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign error_o       = error_q;
    assign err_idx_o     = err_idx_q;
endmodule

// File: tb/tb_axis_i2c_cmd_seq.sv
// Directed bench for the I2C command sequencer.
module tb_axis_i2c_cmd_seq;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 4;

    logic              clk = 1'b0;
    logic              arst;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic [IDX_W:0]    num_cmds;
    logic              loop_en, start, stop, i2c_done, i2c_nack;
    logic              busy, done, error;
    logic [IDX_W-1:0]  err_idx;
    int                total = 0;
    int                bad   = 0;

    axis_i2c_cmd_seq_if #(.DATA_W(DATA_W)) axis ();

    axis_i2c_cmd_seq #(.DATA_W(DATA_W), .NUM_ENTRIES(16), .MAX_RETRY(3)) dut (
        .clk_i(clk), .arst_i(arst), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_wdata_i(cfg_wdata), .num_cmds_i(num_cmds), .loop_en_i(loop_en),
        .start_i(start), .stop_i(stop), .m_axis(axis.master),
        .i2c_done_i(i2c_done), .i2c_nack_i(i2c_nack), .busy_o(busy),
        .done_o(done), .error_o(error), .err_idx_o(err_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [IDX_W-1:0] a, input logic [DATA_W-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic go(input logic [IDX_W:0] n, input logic lp);
        num_cmds = n; loop_en = lp; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && axis.tvalid !== 1'b1; i++) tick();
        chk({tag, "_tvalid"}, 32'(axis.tvalid), 32'd1);
    endtask

    task automatic respond(input logic nack);
        tick(); tick();
        i2c_done = 1'b1; i2c_nack = nack;
        tick();
        i2c_done = 1'b0; i2c_nack = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [DATA_W-1:0] d, input logic last,
                        input logic nack);
        wait_valid(tag);
        chk({tag, "_tdata"}, 32'(axis.tdata), 32'(d));
        chk({tag, "_tlast"}, 32'(axis.tlast), 32'(last));
        tick();
        chk({tag, "_accepted"}, 32'(axis.tvalid), 32'd0);
        respond(nack);
    endtask

    initial begin
        arst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; num_cmds = '0;
        loop_en = 1'b0; start = 1'b0; stop = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
        axis.tready = 1'b1;
        tick(); tick();
        arst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tvalid", 32'(axis.tvalid), 32'd0);
        chk("rst_tdata", 32'(axis.tdata), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_err_idx", 32'(err_idx), 32'd0);

        wr(4'd0, 16'h1011); wr(4'd1, 16'h1022); wr(4'd2, 16'h1033); wr(4'd3, 16'h1044);

        // T1: plain four-entry pass
        go(5'd4, 1'b0);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_lat1", 32'(axis.tvalid), 32'd0);
        tick();
        chk("t1_lat2", 32'(axis.tvalid), 32'd1);
        beat("t1_b0", 16'h1011, 1'b0, 1'b0);
        chk("t1_ack_lat1", 32'(axis.tvalid), 32'd0);
        tick();
        chk("t1_ack_lat2", 32'(axis.tvalid), 32'd1);
        beat("t1_b1", 16'h1022, 1'b0, 1'b0);
        beat("t1_b2", 16'h1033, 1'b0, 1'b0);
        beat("t1_b3", 16'h1044, 1'b1, 1'b0);
        chk("t1_done", 32'(done), 32'd1);
        tick();
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // T2: backpressure on beat 2, plus table write to that entry mid-stall
        go(5'd4, 1'b0);
        beat("t2_b0", 16'h1011, 1'b0, 1'b0);
        axis.tready = 1'b0;
        wait_valid("t2_b1");
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_wdata = 16'h1099;
        for (int i = 0; i < 5; i++) begin
            chk("t2_stall_tvalid", 32'(axis.tvalid), 32'd1);
            chk("t2_stall_tdata", 32'(axis.tdata), 32'h1022);
            chk("t2_stall_tlast", 32'(axis.tlast), 32'd0);
            tick();
            cfg_we = 1'b0;
        end
        axis.tready = 1'b1;
        chk("t2_hold_tdata", 32'(axis.tdata), 32'h1022);
        tick();
        chk("t2_once", 32'(axis.tvalid), 32'd0);
        tick();
        chk("t2_once2", 32'(axis.tvalid), 32'd0);
        tick();
        i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;
        beat("t2_b2", 16'h1033, 1'b0, 1'b0);
        beat("t2_b3", 16'h1044, 1'b1, 1'b0);
        chk("t2_done", 32'(done), 32'd1);
        tick();
        wr(4'd1, 16'h1022);

        // T3: entry 1 NACKs twice then acks
        go(5'd4, 1'b0);
        beat("t3_b0", 16'h1011, 1'b0, 1'b0);
        beat("t3_b1a", 16'h1022, 1'b0, 1'b1);
        chk("t3_retry_lat", 32'(axis.tvalid), 32'd1);
        beat("t3_b1b", 16'h1022, 1'b0, 1'b1);
        beat("t3_b1c", 16'h1022, 1'b0, 1'b0);
        beat("t3_b2", 16'h1033, 1'b0, 1'b0);
        beat("t3_b3", 16'h1044, 1'b1, 1'b0);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_error", 32'(error), 32'd0);
        tick();

        // T4: entry 2 always NACKs -> abort after 1 + 3 retries
        go(5'd4, 1'b0);
        beat("t4_b0", 16'h1011, 1'b0, 1'b0);
        beat("t4_b1", 16'h1022, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) beat("t4_b2", 16'h1033, 1'b0, 1'b1);
        chk("t4_error", 32'(error), 32'd1);
        chk("t4_err_idx", 32'(err_idx), 32'd2);
        chk("t4_no_done", 32'(done), 32'd0);
        chk("t4_idle", 32'(busy), 32'd0);
        tick();
        chk("t4_no_resend", 32'(axis.tvalid), 32'd0);
        chk("t4_sticky", 32'(error), 32'd1);
        go(5'd1, 1'b0);
        chk("t4_err_clr", 32'(error), 32'd0);
        beat("t4_single", 16'h1011, 1'b1, 1'b0);
        chk("t4_single_done", 32'(done), 32'd1);
        tick();

        // T5: loop playback, ignored start while busy, graceful stop
        go(5'd2, 1'b1);
        wait_valid("t5_p0e0");
        chk("t5_p0e0_tdata", 32'(axis.tdata), 32'h1011);
        tick();
        num_cmds = 5'd0; start = 1'b1;
        tick();
        start = 1'b0; num_cmds = 5'd2;
        chk("t5_start_ignored", 32'(busy), 32'd1);
        i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;
        beat("t5_p0e1", 16'h1022, 1'b1, 1'b0);
        chk("t5_loop_busy", 32'(busy), 32'd1);
        beat("t5_p1e0", 16'h1011, 1'b0, 1'b0);
        wait_valid("t5_p1e1");
        chk("t5_p1e1_tdata", 32'(axis.tdata), 32'h1022);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_stop_accept", 32'(axis.tvalid), 32'd0);
        respond(1'b0);
        chk("t5_stop_done", 32'(done), 32'd1);
        tick();
        chk("t5_stop_idle", 32'(busy), 32'd0);
        chk("t5_stop_quiet", 32'(axis.tvalid), 32'd0);

        // T6: empty pass, then reset mid-WAIT, then stray status in IDLE
        go(5'd0, 1'b0);
        chk("t6_zero_done", 32'(done), 32'd1);
        chk("t6_zero_tvalid", 32'(axis.tvalid), 32'd0);
        tick();
        chk("t6_zero_idle", 32'(busy), 32'd0);
        go(5'd3, 1'b0);
        wait_valid("t6_b0");
        tick();
        arst = 1'b1;
        tick();
        arst = 1'b0;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_tvalid", 32'(axis.tvalid), 32'd0);
        chk("t6_rst_tdata", 32'(axis.tdata), 32'd0);
        chk("t6_rst_tlast", 32'(axis.tlast), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_err_idx", 32'(err_idx), 32'd0);
        i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;
        tick();
        chk("t6_stray_done", 32'(busy), 32'd0);
        chk("t6_stray_pulse", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
